// File: rtl/segscan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// One shared hex decoder is sequenced across the digits with a blanking gap; writes commit on frame boundaries.

module segled (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

module segscan_ctrl #(
    parameter int NDIGITS   = 4,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic                   lzs,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame_done,
    output logic                   pending
);

    localparam int VAL_W   = 4 * NDIGITS;
    localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIG_W   = $clog2(NDIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NDIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIG_W-1:0]     digit_q, digit_d;
    logic [VAL_W-1:0]     shadow_val_q, shadow_val_d;
    logic [NDIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [VAL_W-1:0]     disp_val_q, disp_val_d;
    logic [NDIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                 pending_q, pending_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [NDIGITS-1:0]   an_q, an_d;
    logic                 frame_done_q, frame_done_d;

    logic                 phase_last;
    logic                 wrap;
    logic                 commit;
    logic [3:0]           nibble;
    logic [6:0]           dec_seg;
    logic [NDIGITS-1:0]   supp;
    logic                 zero_run;

    always_comb begin
        phase_last = (state_q == ST_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == SHOW_LAST);
        wrap       = (state_q == ST_SHOW) && (cnt_q == SHOW_LAST) && (digit_q == DIG_LAST);
        commit     = en && wrap && pending_q;
        nibble     = disp_val_q[{digit_q, 2'b00} +: 4];
    end

    segled u_segled (
        .hex (nibble),
        .seg (dec_seg)
    );

    // A digit is blanked while everything from the top down to it is zero and it has no dp
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (disp_val_q[4*i +: 4] == 4'h0);
            supp[i]  = lzs & zero_run & ~disp_dp_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        if (!en) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            digit_d = '0;
        end else if (phase_last) begin
            cnt_d = '0;
            if (state_q == ST_BLANK) begin
                state_d = ST_SHOW;
            end else begin
                state_d = ST_BLANK;
                digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are derived from the current sequencer state and registered once
    always_comb begin
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        an_d         = '1;
        frame_done_d = en & wrap;
        if (en && (state_q == ST_SHOW) && !supp[digit_q]) begin
            seg_d          = dec_seg;
            dp_d           = ~disp_dp_q[digit_q];
            an_d[digit_q]  = 1'b0;
        end
    end

    // A load coinciding with the commit still lands in shadow and stays pending
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;
        if (commit) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
            pending_d  = 1'b0;
        end
        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            digit_q      <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_segscan_ctrl.sv
// Bench for segscan_ctrl: frame-position reference model feeding a scoreboard, plus directed scenarios.
module tb_segscan_ctrl;

    localparam int ND    = 4;
    localparam int DV    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = BC + DV;
    localparam int FRAME = ND * SLOT;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        load  = 1'b0;
    logic        lzs   = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    always #5 clk = ~clk;

    segscan_ctrl #(.NDIGITS(ND), .DIV(DV), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .lzs        (lzs),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done),
        .pending    (pending)
    );

    logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [13:0] sbq [$];

    // Reference state: position within the frame plus the two register banks
    int          m_t;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_ddp, m_sdp;
    logic        m_pend;

    function automatic bit suppressed(input int d);
        if (d == 0 || !lzs || m_ddp[d]) return 1'b0;
        for (int j = d; j < ND; j++)
            if (m_disp[4*j +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_loop();
        logic [6:0] es;
        logic       ed, efd, last, com;
        logic [3:0] ea;
        int         dig;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_t = 0; m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0; m_pend = 1'b0;
                sbq.push_back({7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
            end else begin
                es = 7'h7F; ed = 1'b1; ea = 4'hF; efd = 1'b0;
                last = (m_t == FRAME - 1);
                if (en) begin
                    dig = m_t / SLOT;
                    if ((m_t % SLOT) >= BC && !suppressed(dig)) begin
                        ea  = ~(4'b0001 << dig);
                        es  = SEG_TAB[m_disp[4*dig +: 4]];
                        ed  = ~m_ddp[dig];
                    end
                    efd = last;
                end
                com = en && last && m_pend;
                if (com) begin
                    m_disp = m_shadow; m_ddp = m_sdp; m_pend = 1'b0;
                end
                if (load) begin
                    m_shadow = value; m_sdp = dp_in; m_pend = 1'b1;
                end
                m_t = en ? (m_t + 1) % FRAME : 0;
                sbq.push_back({es, ed, ea, efd, m_pend});
            end
        end
    endtask

    task automatic monitor_loop();
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_tests++;
                if ({seg, dp, an, frame_done, pending} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: seg=%h dp=%b an=%h fd=%b pend=%b, expected seg=%h dp=%b an=%h fd=%b pend=%b",
                             $time, seg, dp, an, frame_done, pending, e[13:7], e[6], e[5:2], e[1], e[0]);
                end
            end
        end
    endtask

    task automatic wait_fd(input string name, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check({name, "_fd_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic first_lit(input string name);
        int         cyc = 0;
        logic [3:0] a   = 4'hF;
        for (int k = 1; k <= FRAME && a == 4'hF; k++) begin
            @(negedge clk);
            if (an != 4'hF) begin
                cyc = k; a = an;
            end
        end
        check({name, "_latency"}, 32'(cyc), 32'd3);
        check({name, "_digit"}, 32'(a), 32'hE);
    endtask

    task automatic async_reset(input string name, input bit need_lit);
        for (int k = 0; k < 2 * FRAME && need_lit && an == 4'hF; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({name, "_seg"}, 32'(seg), 32'h7F);
        check({name, "_an"}, 32'(an), 32'hF);
        check({name, "_dp"}, 32'(dp), 32'd1);
        check({name, "_pending"}, 32'(pending), 32'd0);
        check({name, "_fd"}, 32'(frame_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic stimulus();
        logic [6:0] exp12 [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
        logic [3:0] ea, litmask;
        logic [6:0] es;
        bit         ok, dp2ok, seg5ok;
        int         fdcnt;

        @(negedge clk);
        @(negedge clk);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_an", 32'(an), 32'hF);
        check("reset_dp", 32'(dp), 32'd1);
        check("reset_fd", 32'(frame_done), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);

        // Plain scan of 12AF
        rst_n = 1'b1; en = 1'b1; value = 16'h12AF; dp_in = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load_pending", 32'(pending), 32'd1);
        wait_fd("commit12AF", 2 * FRAME);
        check("commit12AF_pending", 32'(pending), 32'd0);
        ok = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            ea = ((k % SLOT) < BC) ? 4'hF : ~(4'b0001 << (k / SLOT));
            es = ((k % SLOT) < BC) ? 7'h7F : exp12[k / SLOT];
            if (ok && (an !== ea || seg !== es || frame_done !== (k == FRAME - 1))) begin
                ok = 1'b0;
                $display("FAIL frame12AF k=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                         k, an, seg, frame_done, ea, es, (k == FRAME - 1));
            end
        end
        n_tests++;
        if (!ok) n_fail++;

        // Tear-free update mid-frame
        repeat (8) @(negedge clk);
        value = 16'h0000; dp_in = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("midframe_pending", 32'(pending), 32'd1);
        wait_fd("commit0000", FRAME + 2);
        check("commit0000_pending", 32'(pending), 32'd0);

        // Leading-zero suppression with a dp on digit 2
        lzs = 1'b1; value = 16'h0050; dp_in = 4'b0100; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd("commit0050", FRAME + 2);
        litmask = '0; dp2ok = 1'b0; seg5ok = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            litmask = litmask | ~an;
            if (an == 4'hB && dp == 1'b0 && seg == 7'h40) dp2ok = 1'b1;
            if (an == 4'hD && seg == 7'h12) seg5ok = 1'b1;
        end
        check("lzs_litmask", 32'(litmask), 32'h7);
        check("lzs_digit2_dp", 32'(dp2ok), 32'd1);
        check("lzs_digit1_seg", 32'(seg5ok), 32'd1);

        // Load collision with the commit cycle
        lzs = 1'b0; value = 16'h1111; dp_in = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 2 * FRAME && m_t != FRAME - 1; k++) @(negedge clk);
        value = 16'h2222; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("collision_fd", 32'(frame_done), 32'd1);
        check("collision_pending", 32'(pending), 32'd1);
        wait_fd("commit2222", FRAME + 2);
        check("commit2222_pending", 32'(pending), 32'd0);

        // Enable dropped during digit 2
        for (int k = 0; k < 2 * FRAME && an != 4'hB; k++) @(negedge clk);
        en = 1'b0;
        fdcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (frame_done) fdcnt++;
        end
        check("en_off_fd", 32'(fdcnt), 32'd0);
        check("en_off_an", 32'(an), 32'hF);
        en = 1'b1;
        first_lit("en_restart");

        // Asynchronous reset mid-SHOW
        async_reset("rst_mid", 1'b1);
        first_lit("rst_restart");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            load  = ($urandom_range(0, 15) == 0);
            value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 49) == 0) lzs = ~lzs;
            if (en && $urandom_range(0, 199) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
            if (i == 700) begin
                load = 1'b0;
                async_reset("rst_rand", 1'b0);
            end
        end
        load = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        fork
            model_loop();
            monitor_loop();
            stimulus();
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
